// File: rtl/mdr_load_seq.sv
// mdr_load_seq: load sequencer with alignment check, fixed-latency word read
// and a memory data register holding the right-justified byte/halfword/word.
`timescale 1ns/1ps

module mdr_load_seq #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [1:0]  load_size_control,
    input  logic [31:0] mem_data_in,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic [31:0] mdr_out,
    output logic [1:0]  load_size_ctrl_out,
    output logic        busy,
    output logic        done,
    output logic        misalign_exc
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        addr_q;
    logic [1:0]         size_q;
    logic               aligned_c;
    logic [31:0]        lane_c;

    // Alignment of the incoming request: lb always ok, lh needs even, lw needs word.
    always_comb begin
        aligned_c = 1'b1;
        if (load_size_control[1]) begin
            aligned_c = 1'b1;
        end else if (load_size_control[0]) begin
            aligned_c = (addr[0] == 1'b0);
        end else begin
            aligned_c = (addr[1:0] == 2'b00);
        end
    end

    // Right-justify the addressed lane; upper bits pass through as shifted.
    always_comb begin
        lane_c = mem_data_in;
        if (size_q[1]) begin
            lane_c = mem_data_in >> {addr_q[1:0], 3'b000};
        end else if (size_q[0]) begin
            lane_c = mem_data_in >> {addr_q[1], 4'b0000};
        end
    end

    // Word-aligned read address, stable from REQ through capture.
    assign mem_addr = {addr_q[31:2], 2'b00};

    // Sequencer FSM with registered strobes and MDR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            cnt                <= '0;
            addr_q             <= '0;
            size_q             <= '0;
            mdr_out            <= '0;
            load_size_ctrl_out <= '0;
            mem_rd             <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            misalign_exc       <= 1'b0;
        end else begin
            mem_rd       <= 1'b0;
            done         <= 1'b0;
            misalign_exc <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q <= addr;
                        size_q <= load_size_control;
                        if (aligned_c) begin
                            state  <= REQ;
                            mem_rd <= 1'b1;
                            busy   <= 1'b1;
                        end else begin
                            misalign_exc <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    cnt   <= CNT_W'(MEM_LATENCY - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        mdr_out            <= lane_c;
                        load_size_ctrl_out <= size_q;
                        done               <= 1'b1;
                        busy               <= 1'b0;
                        state              <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_load_seq.sv
// tb_mdr_load_seq: scoreboard bench with a fixed-latency memory responder.
`timescale 1ns/1ps

module tb_mdr_load_seq;

    localparam int unsigned LAT = 3;
    localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] addr = '0;
    logic [1:0]  load_size_control = '0;
    logic [31:0] mem_data_in = GARBAGE;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mdr_out;
    logic [1:0]  load_size_ctrl_out;
    logic        busy;
    logic        done;
    logic        misalign_exc;

    mdr_load_seq #(.MEM_LATENCY(LAT)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .addr               (addr),
        .load_size_control  (load_size_control),
        .mem_data_in        (mem_data_in),
        .mem_addr           (mem_addr),
        .mem_rd             (mem_rd),
        .mdr_out            (mdr_out),
        .load_size_ctrl_out (load_size_ctrl_out),
        .busy               (busy),
        .done               (done),
        .misalign_exc       (misalign_exc)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        exc;
        logic [31:0] mdr;
        logic [1:0]  size;
        logic [31:0] maddr;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] model_mdr = '0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Memory model: word appears on mem_data_in exactly LAT cycles after mem_rd.
    logic [31:0] mem [logic [31:0]];
    int          cd = 0;
    logic [31:0] rd_word = '0;
    always @(negedge clk) begin
        if (!reset) begin
            cd = 0;
            mem_data_in = GARBAGE;
        end else if (mem_rd) begin
            cd = LAT;
            rd_word = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
            mem_data_in = GARBAGE;
        end else if (cd > 0) begin
            cd--;
            mem_data_in = (cd == 0) ? rd_word : GARBAGE;
        end else begin
            mem_data_in = GARBAGE;
        end
    end

    // Monitor: pop one expectation per done/misalign event.
    int          rd_cnt = 0;
    logic [31:0] rd_addr = '0;
    always @(negedge clk) begin
        if (!reset) begin
            rd_cnt = 0;
        end else begin
            if (mem_rd) begin
                rd_cnt++;
                rd_addr = mem_addr;
            end
            if (done || misalign_exc) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_event: done=%b misalign_exc=%b with nothing pending (cycle %0d)",
                             done, misalign_exc, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("event_is_exc", 32'(misalign_exc), 32'(mon_e.exc));
                    check("event_is_done", 32'(done), 32'(!mon_e.exc));
                    check("event_cycle", cyc, mon_e.cyc);
                    check("busy_at_event", 32'(busy), 32'h0);
                    if (mon_e.exc) begin
                        check("exc_mdr_held", mdr_out, mon_e.mdr);
                        check("exc_no_mem_rd", 32'(rd_cnt), 32'h0);
                    end else begin
                        check("mdr_out", mdr_out, mon_e.mdr);
                        check("size_out", 32'(load_size_ctrl_out), 32'(mon_e.size));
                        check("mem_addr_at_rd", rd_addr, mon_e.maddr);
                        check("mem_rd_per_done", 32'(rd_cnt), 32'h1);
                    end
                end
                rd_cnt = 0;
            end
        end
    end

    function automatic void push(logic exc, logic [31:0] m, logic [1:0] s, logic [31:0] a,
                                 int unsigned c);
        exp_t e;
        e.exc   = exc;
        e.mdr   = exc ? model_mdr : m;
        e.size  = s;
        e.maddr = {a[31:2], 2'b00};
        e.cyc   = c;
        sb.push_back(e);
        if (!exc) model_mdr = m;
    endfunction

    // One-cycle start pulse with its expected outcome.
    task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic exc,
                         input logic [31:0] m);
        @(negedge clk);
        start = 1'b1;
        addr = a;
        load_size_control = s;
        push(exc, m, s, a, exc ? cyc + 1 : cyc + 2 + LAT);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        n_total++;
        if (sb.size() == 0) n_pass++;
        else begin
            $display("FAIL timeout_%s: %0d events still pending, expected 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mdr_out"}, mdr_out, 32'h0);
        check({tag, "_size_out"}, 32'(load_size_ctrl_out), 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_rd"}, 32'(mem_rd), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_misalign"}, 32'(misalign_exc), 32'h0);
    endtask

    initial begin
        mem[32'h100] = 32'hDEAD_BEEF;
        mem[32'h200] = 32'h1122_3344;
        mem[32'h300] = 32'hAABB_CCDD;
        mem[32'h400] = 32'hCAFE_F00D;

        #1;
        check_zero("por");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors.
        issue(32'h0000_0100, 2'b00, 1'b0, 32'hDEAD_BEEF);
        wait_idle("lw_100");
        issue(32'h0000_0203, 2'b10, 1'b0, 32'h0000_0011);
        wait_idle("lb_203");
        issue(32'h0000_0201, 2'b10, 1'b0, 32'h0011_2233);
        wait_idle("lb_201");
        issue(32'h0000_0302, 2'b01, 1'b0, 32'h0000_AABB);
        wait_idle("lh_302");
        issue(32'h0000_0102, 2'b00, 1'b1, 32'h0);
        wait_idle("lw_mis");
        issue(32'h0000_0101, 2'b01, 1'b1, 32'h0);
        wait_idle("lh_mis");
        issue(32'h0000_0101, 2'b11, 1'b0, 32'h00DE_ADBE);
        wait_idle("lb_101");
        issue(32'h0000_0300, 2'b01, 1'b0, 32'hAABB_CCDD);
        wait_idle("lh_300");

        // Back-to-back: start held high, accepted on each done cycle.
        begin
            int unsigned k;
            @(negedge clk);
            k = cyc;
            start = 1'b1;
            addr = 32'h0000_0400;
            load_size_control = 2'b00;
            push(1'b0, 32'hCAFE_F00D, 2'b00, 32'h400, k + (2 + LAT));
            push(1'b0, 32'h00DE_ADBE, 2'b10, 32'h101, k + 2 * (2 + LAT));
            push(1'b0, 32'h0000_AABB, 2'b01, 32'h302, k + 3 * (2 + LAT));
            @(negedge clk);
            addr = 32'h0000_0101;
            load_size_control = 2'b10;
            repeat (2 + LAT) @(negedge clk);
            addr = 32'h0000_0302;
            load_size_control = 2'b01;
            repeat (2 + LAT) @(negedge clk);
            start = 1'b0;
            wait_idle("b2b");
        end

        // Start pulses while busy are dropped.
        issue(32'h0000_0300, 2'b00, 1'b0, 32'hAABB_CCDD);
        @(negedge clk);
        start = 1'b1;
        addr = 32'h0000_0100;
        load_size_control = 2'b00;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_idle("busy_ignore");
        repeat (10) @(negedge clk);
        check("no_extra_load_mdr", mdr_out, 32'hAABB_CCDD);

        // Reset in the middle of WAIT aborts the access.
        @(negedge clk);
        start = 1'b1;
        addr = 32'h0000_0200;
        load_size_control = 2'b00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_zero("mid_reset");
        model_mdr = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("after_abort_mdr", mdr_out, 32'h0);
        check("after_abort_busy", 32'(busy), 32'h0);

        issue(32'h0000_0200, 2'b00, 1'b0, 32'h1122_3344);
        wait_idle("lw_after_reset");

        repeat (6) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mdr_load_seq.md
# mdr_load_seq

Memory-read sequencer and memory data register (MDR) for load instructions. It sits directly upstream of the load-size stage. On a start pulse from the control unit it checks alignment, issues a word read to data memory, and waits the fixed memory latency. It then captures the addressed byte or halfword, right-justified, into the MDR, so the load-size stage can zero-extend the low bits directly.

## Interface
- MEM_LATENCY, 1, cycles from the cycle `mem_rd` is high to the cycle `mem_data_in` is valid; legal range is 1–15.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- start  in  1  load request from the control unit, sampled when not busy.
- addr  in  32  byte address of the load (ALUOut).
- load_size_control  in  2  00 = lw, 01 = lh, 1x = lb (bit 1 wins); same encoding as the load-size stage.
- mem_data_in  in  32  word read from data memory, little-endian.
- mem_addr  out  32  word-aligned read address {addr_q[31:2], 2'b00}.
- mem_rd  out  1  read strobe, high for exactly one cycle per access.
- mdr_out  out  32  MDR contents, feeding the load-size stage.
- load_size_ctrl_out  out  2  captured size code, held with the MDR.
- busy  out  1  access in progress.
- done  out  1  one-cycle pulse: MDR updated this cycle.
- misalign_exc  out  1  one-cycle pulse: request rejected for alignment.

## Operation
- States: IDLE, REQ, WAIT.
- In IDLE with start = 1:
  - Capture addr into addr_q and the size code into size_q.
  - Alignment check: lw needs addr[1:0] = 00; lh needs addr[0] = 0; lb is always aligned.
  - Aligned → go to REQ. Misaligned → stay in IDLE, pulse misalign_exc next cycle. No memory access; MDR and load_size_ctrl_out are unchanged.
- REQ: mem_rd = 1; load the latency counter with MEM_LATENCY−1; go to WAIT.
- WAIT: decrement the counter. When the counter is 0, mem_data_in is valid in that cycle:
  - Capture the lane-shifted data into the MDR.
  - Copy size_q to load_size_ctrl_out.
  - Set done = 1 for the next cycle and go to IDLE.
- Lane shift before capture:
  - lw: the whole word.
  - lh: mem_data_in >> (16·addr_q[1]).
  - lb: mem_data_in >> (8·addr_q[1:0]).
  - Upper bits are passed as shifted. The downstream stage masks them.
- busy = 1 in REQ and WAIT only.
- mem_addr is driven from addr_q in all states, so it is stable from REQ through capture.
- start while busy is ignored (not queued).
- The done cycle is an IDLE cycle, so start is accepted then (back-to-back loads).
- Asynchronous reset while reset = 0:
  - state IDLE, counter 0, addr_q/size_q 0.
  - mdr_out 0, load_size_ctrl_out 00.
  - mem_rd, busy, done, misalign_exc all 0.
- Reset mid-access aborts it: no done, and the MDR keeps its reset value.

## Timing
- Cycle 0: start sampled at the edge.
- Cycle 1: state REQ, mem_rd = 1, busy = 1.
- Cycles 2 … 1+MEM_LATENCY: state WAIT; data sampled at the end of cycle 1+MEM_LATENCY.
- Cycle 2+MEM_LATENCY: mdr_out and load_size_ctrl_out hold the new value, done = 1, busy = 0.
- Start-to-done latency is 2+MEM_LATENCY cycles; peak throughput is one load per 2+MEM_LATENCY cycles.
- misalign_exc is high in cycle 1 only; busy stays 0.
- mdr_out is registered and holds its value until the next successful capture.

## Test plan
- Reset: assert reset low mid-WAIT → all outputs read 0 immediately; release, no done ever appears; a later lw completes normally.
- lw, MEM_LATENCY = 1: start, addr = 0x100, mem_data_in = 0xDEADBEEF in cycle 2 → mem_rd in cycle 1 with mem_addr = 0x100, done in cycle 3, mdr_out = 0xDEADBEEF, load_size_ctrl_out = 00.
- lb lane select: code 10, addr = 0x203, word 0x11223344 → mdr_out[7:0] = 0x11, mem_addr = 0x200. Repeat with addr = 0x201 → mdr_out[7:0] = 0x33.
- lh lane select: code 01, addr = 0x302, word 0xAABBCCDD → mdr_out[15:0] = 0xAABB.
- Misalignment:
  - lw at 0x102 → misalign_exc pulse in cycle 1, mem_rd never asserted, mdr_out unchanged.
  - lh at 0x101 → same response.
  - lb at 0x101 → completes normally.
- Back-to-back and busy: start held high with MEM_LATENCY = 3 → done every 5 cycles. Extra start pulses during busy are ignored, giving exactly one mem_rd per done.
